// File: rtl/triad_decoder_bank.sv
// triad_decoder_bank: N-channel serial triad decoder with stretched/latched hits and saturating skip counters
module triad_decoder_bank #(
    parameter int NCH  = 8,
    parameter int PW   = 4,
    parameter int CNTW = 16,
    parameter int SELW = 3
) (
    input  logic              clk,
    input  logic              _reset,
    input  logic              lctrst,
    input  logic [NCH-1:0]    distrip,
    input  logic [PW-1:0]     persist,
    input  logic              latch_mode,
    input  logic              hits_clr,
    input  logic              skip_clr,
    input  logic [SELW-1:0]   cnt_sel,
    output logic [4*NCH-1:0]  halfstrips,
    output logic [NCH-1:0]    triad_skip,
    output logic              skip_any,
    output logic [CNTW-1:0]   skip_cnt
);
    typedef enum logic [1:0] {IDLE, B1, B2} state_t;

    logic [1:0]      rst_sync;
    logic            rst_n;
    logic [CNTW-1:0] cnts [NCH];

    assign rst_n = rst_sync[1];

    // reset asserts immediately, releases two clock edges after _reset rises
    always_ff @(posedge clk or negedge _reset)
        if (!_reset) rst_sync <= '0;
        else         rst_sync <= {rst_sync[0], 1'b1};

    for (genvar c = 0; c < NCH; c++) begin : g_ch
        state_t          state, state_nxt;
        logic            b1, ev, skip, skip_q;
        logic [3:0]      hit, hit_new;
        logic [PW-1:0]   timer;
        logic [CNTW-1:0] cnt;

        // triad sequencing: start bit, b1, b2; decode fires while in B2
        always_comb begin
            state_nxt = lctrst ? IDLE :
                        state == IDLE ? (distrip[c] ? B1 : IDLE) :
                        state == B1   ? B2 : IDLE;
            ev        = !lctrst && state == B2;
            hit_new   = 4'b0001 << {b1, distrip[c]};
            skip      = ev && !latch_mode && timer != '0;
        end

        // FSM state register and first-bit capture
        always_ff @(posedge clk or negedge rst_n)
            if (!rst_n) begin
                state <= IDLE;
                b1    <= 1'b0;
            end else begin
                state <= state_nxt;
                b1    <= state == B1 ? distrip[c] : b1;
            end

        // hit nibble, hold timer and skip pulse; a timer of 0 is the last held cycle
        always_ff @(posedge clk or negedge rst_n)
            if (!rst_n) begin
                hit    <= '0;
                timer  <= '0;
                skip_q <= 1'b0;
            end else if (lctrst) begin
                hit    <= '0;
                timer  <= '0;
                skip_q <= 1'b0;
            end else begin
                skip_q <= skip;
                if (latch_mode) begin
                    hit   <= (hits_clr ? 4'h0 : hit) | (ev ? hit_new : 4'h0);
                    timer <= '0;
                end else if (ev && timer == '0) begin
                    hit   <= hit_new;
                    timer <= persist;
                end else if (timer != '0) begin
                    timer <= timer - 1'b1;
                end else begin
                    hit   <= '0;
                end
            end

        // saturating skip counter fed by the registered skip pulse; clear wins
        always_ff @(posedge clk or negedge rst_n)
            if (!rst_n)                       cnt <= '0;
            else if (skip_clr)                cnt <= '0;
            else if (skip_q && cnt != '1)     cnt <= cnt + 1'b1;

        assign halfstrips[4*c +: 4] = hit;
        assign triad_skip[c]        = skip_q;
        assign cnts[c]              = cnt;
    end

    // registered skip summary and counter readback mux
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            skip_any <= 1'b0;
            skip_cnt <= '0;
        end else begin
            skip_any <= |triad_skip;
            skip_cnt <= 32'(cnt_sel) < NCH ? cnts[cnt_sel] : '0;
        end
endmodule

// File: tb/tb_triad_decoder_bank.sv
// tb_triad_decoder_bank: scoreboard bench for triad_decoder_bank against a cycle-number based model
module tb_triad_decoder_bank;
    localparam int NCH  = 12;
    localparam int PW   = 4;
    localparam int CNTW = 4;
    localparam int SELW = 4;

    logic clk = 1'b0;
    logic rst_in, lctrst, latch_mode, hits_clr, skip_clr;
    logic [NCH-1:0]   distrip;
    logic [PW-1:0]    persist;
    logic [SELW-1:0]  cnt_sel;
    logic [4*NCH-1:0] halfstrips;
    logic [NCH-1:0]   triad_skip;
    logic             skip_any;
    logic [CNTW-1:0]  skip_cnt;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [4*NCH-1:0] hs;
        logic [NCH-1:0]   sk;
        logic             any;
        logic [CNTW-1:0]  cnt;
    } exp_t;
    exp_t q[$];

    int nbits [NCH];
    int hsv [NCH];
    int hold_end [NCH];
    int mcnt [NCH];
    logic [3:0] nib [NCH];
    logic [NCH-1:0] skvis;
    int hold = 0;
    int k = 0;

    always #5 clk = ~clk;

    triad_decoder_bank #(.NCH(NCH), .PW(PW), .CNTW(CNTW), .SELW(SELW)) dut (
        .clk(clk), ._reset(rst_in), .lctrst(lctrst), .distrip(distrip), .persist(persist),
        .latch_mode(latch_mode), .hits_clr(hits_clr), .skip_clr(skip_clr), .cnt_sel(cnt_sel),
        .halfstrips(halfstrips), .triad_skip(triad_skip), .skip_any(skip_any), .skip_cnt(skip_cnt)
    );

    task automatic chk(input string n, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s at %0t: got %h expected %h", n, $time, act, req);
        end
    endtask

    // model the response for the cycle after this one's inputs are sampled, then advance a cycle
    task automatic tick();
        exp_t e;
        logic [NCH-1:0] skn;
        int b;
        e = '0;
        skn = '0;
        if (!rst_in || hold > 0) begin
            hold = !rst_in ? 2 : hold - 1;
            for (int c = 0; c < NCH; c++) begin
                nbits[c] = 0; nib[c] = 0; hold_end[c] = -1; mcnt[c] = 0;
            end
            skvis = '0;
        end else begin
            e.any = |skvis;
            e.cnt = (int'(cnt_sel) < NCH) ? CNTW'(mcnt[cnt_sel]) : '0;
            for (int c = 0; c < NCH; c++) begin
                mcnt[c] = skip_clr ? 0 : (skvis[c] && mcnt[c] < 2**CNTW - 1) ? mcnt[c] + 1 : mcnt[c];
                if (lctrst) begin
                    nbits[c] = 0; nib[c] = 0; hold_end[c] = -1;
                end else begin
                    b = int'(distrip[c]);
                    if (latch_mode && hits_clr) nib[c] = 0;
                    if (nbits[c] == 0) begin
                        if (b == 1) nbits[c] = 1;
                    end else if (nbits[c] == 1) begin
                        hsv[c] = 2 * b; nbits[c] = 2;
                    end else begin
                        hsv[c] += b; nbits[c] = 0;
                        if (latch_mode) nib[c] |= 4'(1 << hsv[c]);
                        else if (hold_end[c] >= k + 1) skn[c] = 1'b1;
                        else begin
                            nib[c] = 4'(1 << hsv[c]);
                            hold_end[c] = k + 1 + int'(persist);
                        end
                    end
                end
                e.hs[4*c +: 4] = (latch_mode || k + 1 <= hold_end[c]) ? nib[c] : 4'h0;
            end
            skvis = skn;
            e.sk = skn;
        end
        k++;
        q.push_back(e);
        @(posedge clk);
        #2;
    endtask

    task automatic idle(input int n);
        distrip = '0;
        repeat (n) tick();
    endtask

    task automatic triad(input int ch, input logic b1, input logic b2);
        distrip = '0; distrip[ch] = 1'b1; tick();
        distrip[ch] = b1; tick();
        distrip[ch] = b2; tick();
        distrip = '0;
    endtask

    task automatic do_reset();
        rst_in = 1'b0; distrip = '0; lctrst = 0; hits_clr = 0; skip_clr = 0;
        tick(); tick();
        rst_in = 1'b1;
        tick(); tick(); tick();
    endtask

    // monitor: compare every presented cycle against the oldest queued expectation
    initial forever begin
        @(posedge clk);
        #1;
        if (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            chk("halfstrips", 64'(halfstrips), 64'(e.hs));
            chk("triad_skip", 64'(triad_skip), 64'(e.sk));
            chk("skip_any", 64'(skip_any), 64'(e.any));
            chk("skip_cnt", 64'(skip_cnt), 64'(e.cnt));
        end
    end

    initial begin
        rst_in = 1'b1; lctrst = 0; latch_mode = 0; hits_clr = 0; skip_clr = 0;
        distrip = '0; persist = '0; cnt_sel = '0;
        #1 rst_in = 1'b0;
        @(posedge clk);
        #2;
        do_reset();

        persist = 4'd3;
        idle(3); triad(2, 1'b1, 1'b0); idle(6);

        persist = 4'd5; cnt_sel = 4'd0;
        triad(0, 1'b0, 1'b1); triad(0, 1'b1, 1'b1); idle(8);

        latch_mode = 1'b1; do_reset();
        triad(7, 1'b0, 1'b0); triad(7, 1'b1, 1'b1); idle(3);
        hits_clr = 1'b1; tick(); hits_clr = 1'b0; idle(2);
        triad(7, 1'b1, 1'b0);
        distrip[7] = 1'b1; tick(); distrip[7] = 1'b0; tick();
        distrip[7] = 1'b1; hits_clr = 1'b1; tick(); hits_clr = 1'b0; idle(3);

        latch_mode = 1'b0; do_reset();
        persist = 4'd15; cnt_sel = 4'd1;
        repeat (30) triad(1, 1'b1, 1'b0);
        idle(4);
        repeat (6) triad(1, 1'b0, 1'b0);
        skip_clr = 1'b1; tick(); skip_clr = 1'b0; idle(2);
        repeat (4) triad(1, 1'b0, 1'b1);
        skip_clr = 1'b1; tick(); skip_clr = 1'b0; idle(20);

        persist = 4'd2; cnt_sel = 4'd3;
        distrip[3] = 1'b1; tick(); tick();
        lctrst = 1'b1; tick(); lctrst = 1'b0;
        triad(3, 1'b1, 1'b1); idle(6);

        persist = 4'd10; cnt_sel = 4'd13;
        triad(11, 1'b1, 1'b0); triad(11, 1'b0, 1'b1); idle(2);
        rst_in = 1'b0;
        #1;
        chk("async_reset_hs", 64'(halfstrips), 64'd0);
        chk("async_reset_skip", 64'(triad_skip), 64'd0);
        tick(); tick();
        rst_in = 1'b1;
        idle(3);
        triad(11, 1'b1, 1'b1); idle(14);

        for (int blk = 0; blk < 6; blk++) begin
            latch_mode = (blk % 2 == 1);
            do_reset();
            repeat (500) begin
                for (int c = 0; c < NCH; c++) distrip[c] = ($urandom_range(3) == 0);
                if ($urandom_range(15) == 0) persist = PW'($urandom_range(15));
                lctrst   = ($urandom_range(63) == 0);
                hits_clr = ($urandom_range(15) == 0);
                skip_clr = ($urandom_range(63) == 0);
                cnt_sel  = SELW'($urandom_range(15));
                tick();
            end
            lctrst = 0; hits_clr = 0; skip_clr = 0;
        end

        idle(3);
        chk("scoreboard_drained", 64'(q.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
